// File: rtl/lsu_riscv.sv
// lsu_riscv: load/store unit between the execute stage and the data memory port.
// Runs a req/gnt/rvalid handshake, formats store byte lanes, extends load data
// and stalls the core until the access completes.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned H/HU/W accesses skip
// memory and raise lsu_misalign_o for one cycle instead of being force-aligned).
module lsu_riscv (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_misalign_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state_reg;
  logic [2:0]  size_reg;
  logic [1:0]  offset_reg;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] load_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_reg;
  logic misaligned;

  // Flag halfword accesses on odd bytes and word accesses off a word boundary.
  always_comb begin
    misaligned = 1'b0;
    case (lsu_size_i)
      LDST_H, LDST_HU: misaligned = lsu_addr_i[0];
      LDST_W:          misaligned = (lsu_addr_i[1:0] != 2'b00);
      default:         misaligned = 1'b0;
    endcase
  end

  assign lsu_misalign_o = misalign_reg;
`else
  assign lsu_misalign_o = 1'b0;
`endif

  // Stall is combinational so the core freezes in the very cycle it requests.
  assign lsu_stall_req_o = lsu_req_i && (state_reg != DONE);

  // Byte enables and lane-replicated store data from the incoming request;
  // unused low address bits simply drop out of the shift amounts.
  always_comb begin
    be_next    = 4'b0001 << lsu_addr_i[1:0];
    wdata_next = {4{lsu_data_i[7:0]}};
    case (lsu_size_i)
      LDST_H, LDST_HU: begin
        be_next    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata_next = {2{lsu_data_i[15:0]}};
      end
      LDST_W: begin
        be_next    = 4'b1111;
        wdata_next = lsu_data_i;
      end
      default: begin
        be_next    = 4'b0001 << lsu_addr_i[1:0];
        wdata_next = {4{lsu_data_i[7:0]}};
      end
    endcase
  end

  // Pick the addressed byte/halfword out of the read word and extend it.
  always_comb begin
    byte_sel = data_rdata_i[7:0];
    case (offset_reg)
      2'd0: byte_sel = data_rdata_i[7:0];
      2'd1: byte_sel = data_rdata_i[15:8];
      2'd2: byte_sel = data_rdata_i[23:16];
      2'd3: byte_sel = data_rdata_i[31:24];
      default: byte_sel = data_rdata_i[7:0];
    endcase
    half_sel = offset_reg[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size_reg)
      LDST_H:  load_ext = {{16{half_sel[15]}}, half_sel};
      LDST_W:  load_ext = data_rdata_i;
      LDST_BU: load_ext = {24'd0, byte_sel};
      LDST_HU: load_ext = {16'd0, half_sel};
      default: load_ext = {{24{byte_sel[7]}}, byte_sel};
    endcase
  end

  // Access FSM with registered memory-side outputs and load result.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_reg    <= IDLE;
      size_reg     <= LDST_B;
      offset_reg   <= 2'd0;
      lsu_data_o   <= 32'd0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'd0;
      data_addr_o  <= 32'd0;
      data_wdata_o <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (lsu_req_i) begin
            size_reg     <= lsu_size_i;
            offset_reg   <= lsu_addr_i[1:0];
            data_we_o    <= lsu_we_i;
            data_be_o    <= be_next;
            data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
            data_wdata_o <= wdata_next;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misaligned) begin
              misalign_reg <= 1'b1;
              state_reg    <= DONE;
            end else begin
              data_req_o <= 1'b1;
              state_reg  <= REQ;
            end
`else
            data_req_o <= 1'b1;
            state_reg  <= REQ;
`endif
          end
        end
        REQ: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            state_reg  <= data_we_o ? DONE : RESP;
          end
        end
        RESP: begin
          if (data_rvalid_i) begin
            lsu_data_o <= load_ext;
            state_reg  <= DONE;
          end
        end
        DONE: begin
`ifdef LSU_MISALIGN_TRAP_EN
          misalign_reg <= 1'b0;
`endif
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_riscv.sv
// tb_lsu_riscv: directed bench for lsu_riscv with a small reactive memory model.
module tb_lsu_riscv;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o;
  logic        lsu_misalign_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  int total_cnt = 0;
  int bad_cnt   = 0;

  int          stall_n, req_n, mis_n;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr, cap_wdata;

  always #5 clk_i = ~clk_i;

  lsu_riscv dut (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_data_i     (lsu_data_i),
    .lsu_data_o     (lsu_data_o),
    .lsu_stall_req_o(lsu_stall_req_o),
    .lsu_misalign_o (lsu_misalign_o),
    .data_req_o     (data_req_o),
    .data_we_o      (data_we_o),
    .data_be_o      (data_be_o),
    .data_addr_o    (data_addr_o),
    .data_wdata_o   (data_wdata_o),
    .data_gnt_i     (data_gnt_i),
    .data_rvalid_i  (data_rvalid_i),
    .data_rdata_i   (data_rdata_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // One core access against a memory that grants after gnt_dly wait cycles and
  // returns rvalid rv_dly cycles after the first legal cycle following gnt.
  task automatic do_access(input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
    int  rvc;
    bit  granted;
    bit  done;
    rvc = 0; granted = 0; done = 0;
    stall_n = 0; req_n = 0; mis_n = 0;
    cap_be = 4'd0; cap_addr = 32'd0; cap_wdata = 32'd0;
    @(posedge clk_i); #1;
    lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr; lsu_data_i = wdata;
    lsu_req_i = 1'b1;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk_i);
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      data_rdata_i  = 32'h5A5A_A5A5;
      if (lsu_misalign_o) mis_n++;
      if (!lsu_stall_req_o) begin
        done = 1;
      end else begin
        stall_n++;
        if (data_req_o) begin
          if (req_n == 0) begin
            cap_be = data_be_o; cap_addr = data_addr_o; cap_wdata = data_wdata_o;
          end
          req_n++;
          if (req_n == gnt_dly + 1) begin
            data_gnt_i = 1'b1;
            granted    = 1;
          end
        end else if (granted) begin
          rvc++;
          if (rvc == rv_dly + 1) begin
            data_rvalid_i = 1'b1;
            data_rdata_i  = rdata;
          end
        end
      end
    end
    if (!done) check_eq("access_timeout", 32'd0, 32'd1);
    lsu_req_i = 1'b0;
    @(negedge clk_i);
    if (lsu_misalign_o) mis_n++;
    $display("access we=%0b size=%0d addr=0x%08h stall=%0d req=%0d be=%b data_o=0x%08h",
             we, size, addr, stall_n, req_n, cap_be, lsu_data_o);
  endtask

  initial begin
    arstn_i = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0;
    lsu_addr_i = 32'd0; lsu_data_i = 32'd0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'd0;
    repeat (2) @(negedge clk_i);
    check_eq("rst_req",   {31'd0, data_req_o}, 32'd0);
    check_eq("rst_stall", {31'd0, lsu_stall_req_o}, 32'd0);
    check_eq("rst_data",  lsu_data_o, 32'd0);
    check_eq("rst_be",    {28'd0, data_be_o}, 32'd0);
    @(posedge clk_i); #1 arstn_i = 1'b1;

    // LB / LBU: byte 1 of 0x00008000 is 0x80
    do_access(1'b0, 3'd0, 32'h101, 32'd0, 32'h0000_8000, 0, 0);
    check_eq("lb_data",  lsu_data_o, 32'hFFFF_FF80);
    check_eq("lb_be",    {28'd0, cap_be}, 32'h2);
    check_eq("lb_stall", stall_n, 3);
    do_access(1'b0, 3'd4, 32'h101, 32'd0, 32'h0000_8000, 0, 0);
    check_eq("lbu_data", lsu_data_o, 32'h0000_0080);

    // SW: single-cycle grant
    do_access(1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF, 32'd0, 0, 0);
    check_eq("sw_be",    {28'd0, cap_be}, 32'hF);
    check_eq("sw_addr",  cap_addr, 32'h104);
    check_eq("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
    check_eq("sw_req",   req_n, 1);
    check_eq("sw_stall", stall_n, 2);
    check_eq("sw_keep",  lsu_data_o, 32'h0000_0080);

    // SB: grant delayed three cycles
    do_access(1'b1, 3'd0, 32'h203, 32'h0000_00A5, 32'd0, 3, 0);
    check_eq("sb_be",    {28'd0, cap_be}, 32'h8);
    check_eq("sb_addr",  cap_addr, 32'h200);
    check_eq("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    check_eq("sb_req",   req_n, 4);
    check_eq("sb_stall", stall_n, 5);

    // LH / LHU: upper half of 0x80011234
    do_access(1'b0, 3'd1, 32'h102, 32'd0, 32'h8001_1234, 0, 0);
    check_eq("lh_data",  lsu_data_o, 32'hFFFF_8001);
    check_eq("lh_be",    {28'd0, cap_be}, 32'hC);
    do_access(1'b0, 3'd5, 32'h102, 32'd0, 32'h8001_1234, 0, 0);
    check_eq("lhu_data", lsu_data_o, 32'h0000_8001);

    // Misaligned LW
    do_access(1'b0, 3'd2, 32'h101, 32'd0, 32'hCAFE_BABE, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check_eq("mis_req",   req_n, 0);
    check_eq("mis_flag",  mis_n, 1);
    check_eq("mis_stall", stall_n, 1);
    check_eq("mis_data",  lsu_data_o, 32'h0000_8001);
`else
    check_eq("mis_addr",  cap_addr, 32'h100);
    check_eq("mis_be",    {28'd0, cap_be}, 32'hF);
    check_eq("mis_data",  lsu_data_o, 32'hCAFE_BABE);
    check_eq("mis_flag",  mis_n, 0);
`endif

    // Reset during RESP of a load
    @(posedge clk_i); #1;
    lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h300; lsu_req_i = 1'b1;
    @(negedge clk_i);                   // IDLE
    @(negedge clk_i);                   // REQ
    check_eq("rst_mid_req_seen", {31'd0, data_req_o}, 32'd1);
    data_gnt_i = 1'b1;
    @(negedge clk_i);                   // RESP
    data_gnt_i = 1'b0;
    #2 arstn_i = 1'b0; lsu_req_i = 1'b0;
    #1;
    check_eq("arst_req",   {31'd0, data_req_o}, 32'd0);
    check_eq("arst_data",  lsu_data_o, 32'd0);
    check_eq("arst_addr",  data_addr_o, 32'd0);
    check_eq("arst_stall", {31'd0, lsu_stall_req_o}, 32'd0);
    @(posedge clk_i); #1 arstn_i = 1'b1;

    // Stale rvalid in IDLE must be ignored
    @(posedge clk_i); #1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    check_eq("stale_req", {31'd0, data_req_o}, 32'd0);
    @(posedge clk_i); #1 data_rvalid_i = 1'b0;
    @(negedge clk_i);
    check_eq("stale_data", lsu_data_o, 32'd0);

    // Fresh LW after reset with one wait cycle on gnt and on rvalid
    do_access(1'b0, 3'd2, 32'h100, 32'd0, 32'h1234_5678, 1, 1);
    check_eq("lw_data",  lsu_data_o, 32'h1234_5678);
    check_eq("lw_stall", stall_n, 5);
    check_eq("lw_addr",  cap_addr, 32'h100);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
